// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- RV32I load/store unit controller
//
// Purpose:
//   Takes one load or store request at a time from the pipeline. It talks to a
//   single-port synchronous data memory that only writes whole words. Loads
//   are extracted and sign/zero-extended from the returned word. Sub-word
//   stores (SB/SH) use a read-modify-write sequence. Misaligned or unsupported
//   requests complete immediately with a fault and never touch memory.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous reset, active low (0 = reset)
//   req_valid   in   1   request present
//   req_ready   out  1   request can be accepted (IDLE only)
//   req_we      in   1   1 = store, 0 = load
//   req_funct3  in   3   RV32I width/sign code
//   req_addr    in  32   byte address
//   req_wdata   in  32   store data, right-aligned
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out 32   extended load data, 0 for stores and faults
//   resp_fault  out  1   misaligned or unsupported request, with resp_valid
//   mem_we      out  1   word write strobe
//   mem_addr    out 32   word-aligned byte address
//   mem_wdata   out 32   word to write
//   mem_rdata   in  32   read data, valid one cycle after mem_addr
// -----------------------------------------------------------------------------
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   // IDLE waits for work, READ presents the address, DATA consumes the
   // returned word, WRITE strobes the memory, and RESP is the single-cycle
   // completion.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   // Latched request fields. The upper address bits are not kept here because
   // mem_addr itself is loaded with them at accept time. Only the low half of
   // the store data is needed after accept, because SW writes req_wdata
   // straight into mem_wdata and SB/SH merge at most 16 bits.
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;

   logic        accept;
   logic        req_fault;

   // Decides whether a request can be executed at all. Codes outside the
   // RV32I load/store tables are rejected. Halfwords must be 2-byte aligned
   // and words must be 4-byte aligned; bytes can sit at any address.
   function automatic logic is_fault(input logic       we,
                                     input logic [2:0] f3,
                                     input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      if (we) begin
         case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lo[0];
            3'b010:  bad = (lo != 2'b00);
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = lo[0];
            3'b010:         bad = (lo != 2'b00);
            default:        bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

   // Picks the byte or halfword lane out of a memory word. It then
   // sign-extends (LB/LH) or zero-extends (LBU/LHU) the lane. LW passes the
   // word through unchanged.
   function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b100:  res = {24'h000000, b};
         3'b101:  res = {16'h0000, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Builds the word for a sub-word store. It copies the word just read and
   // overwrites only the addressed byte or halfword lane. Only SB/SH reach
   // here, so funct3[1:0] is either 00 (byte) or 01 (half).
   function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word,
                                               input logic [15:0] wd);
      logic [31:0] res;
      res = word;
      if (f3[1:0] == 2'b00) begin
         case (lane)
            2'd0:    res[7:0]   = wd[7:0];
            2'd1:    res[15:8]  = wd[7:0];
            2'd2:    res[23:16] = wd[7:0];
            default: res[31:24] = wd[7:0];
         endcase
      end else if (lane[1]) begin
         res[31:16] = wd;
      end else begin
         res[15:0] = wd;
      end
      return res;
   endfunction

   // Request-side decode. A request is taken only while the FSM sits in IDLE.
   // The fault check looks at the live request, because a faulting request
   // must go straight to RESP on the accept edge.
   always_comb begin
      req_ready = 1'b0;
      accept    = 1'b0;
      req_fault = 1'b0;
      req_ready = (state == IDLE);
      accept    = req_valid && (state == IDLE);
      req_fault = is_fault(req_we, req_funct3, req_addr[1:0]);
   end

   // Next-state logic. SW needs no read and goes straight to WRITE. Loads,
   // SB and SH read first. Stores leaving DATA still have a write to do.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_fault) begin
                  next_state = RESP;
               end else if (req_we && (req_funct3 == 3'b010)) begin
                  next_state = WRITE;
               end else begin
                  next_state = READ;
               end
            end
         end
         READ:    next_state = DATA;
         DATA:    next_state = we_q ? WRITE : RESP;
         WRITE:   next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register. Reset drops the FSM back to IDLE at once, which also
   // abandons any operation in flight without a response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Captures the request fields needed after the accept edge. These are the
   // lane position, width code, direction and store data for the RMW merge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         lane_q   <= 2'b00;
         wdata_q  <= 16'h0000;
      end else if (accept) begin
         we_q     <= req_we;
         funct3_q <= req_funct3;
         lane_q   <= req_addr[1:0];
         wdata_q  <= req_wdata[15:0];
      end
   end

   // Memory-side registers. The word address is loaded on the accept edge so
   // it is already stable during READ or WRITE. It then holds until the next
   // request. mem_we follows the WRITE state exactly because it is set from
   // next_state. mem_wdata is loaded either with the full SW data on accept,
   // or with the merged word while in DATA for SB/SH. Otherwise it holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0000_0000;
         mem_wdata <= 32'h0000_0000;
      end else begin
         mem_we <= (next_state == WRITE);
         if (accept) begin
            mem_addr <= {req_addr[31:2], 2'b00};
         end
         if ((state == IDLE) && (next_state == WRITE)) begin
            mem_wdata <= req_wdata;
         end else if ((state == DATA) && we_q) begin
            mem_wdata <= store_merge(funct3_q, lane_q, mem_rdata, wdata_q);
         end
      end
   end

   // Response registers, all set on the edge that enters RESP. The only path
   // from IDLE directly to RESP is a fault. The only path from DATA to RESP
   // is a load, whose extracted data is captured from mem_rdata. Stores and
   // faults report zero data. resp_rdata keeps its value between responses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_valid <= 1'b0;
         resp_fault <= 1'b0;
         resp_rdata <= 32'h0000_0000;
      end else begin
         resp_valid <= (next_state == RESP);
         resp_fault <= (state == IDLE) && (next_state == RESP);
         if (next_state == RESP) begin
            if ((state == DATA) && !we_q) begin
               resp_rdata <= load_extract(funct3_q, lane_q, mem_rdata);
            end else begin
               resp_rdata <= 32'h0000_0000;
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl
//
// Purpose:
//   Drives directed load/store requests and keeps a word-array model of memory.
//   For each accepted request it schedules per-cycle expectations for
//   req_ready, resp_* and mem_we/mem_wdata/mem_addr. A compare process checks
//   every cycle against that schedule. A few literal values pin the model.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

   localparam int NCYC = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit checkEn = 1'b0;

   logic        expReady [0:NCYC-1];
   logic        expValid [0:NCYC-1];
   logic        expFault [0:NCYC-1];
   logic [31:0] expRdata [0:NCYC-1];
   logic        expWe    [0:NCYC-1];
   logic [31:0] expWdata [0:NCYC-1];
   logic [31:0] expAddr  [0:NCYC-1];

   logic [31:0] modelMem [0:255];
   logic [31:0] ram [0:255];
   logic        ramLoaded = 1'b0;

   lsu_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // 10 time-unit clock period.
   always #5 clk = ~clk;

   // Cycle index. At a negedge, cyc names the cycle that follows rising edge
   // number cyc.
   always @(posedge clk) cyc <= cyc + 1;

   // Initial RAM image, shared by the memory and the model.
   function automatic logic [31:0] initWord(input int i);
      if (i == 4)  return 32'h8877_6655;
      if (i == 12) return 32'hCAFE_F00D;
      return 32'hA500_0000 | 32'(i * 32'h0001_0203);
   endfunction

   // Synchronous word memory: read-first, registered read data.
   always @(posedge clk) begin
      if (!ramLoaded) begin
         for (int i = 0; i < 256; i++) ram[i] <= initWord(i);
         ramLoaded <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr[9:2]] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr[9:2]];
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, wanted %h", name, cyc, act, exp);
      end
   endtask

   // Reference rules, written as plain arithmetic on whole words.
   function automatic bit modelFault(input bit we, input logic [2:0] f3,
                                     input logic [31:0] a);
      int  sz;
      bit  ok;
      sz = int'(f3[1:0]);
      if (we) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                   (f3 == 3'd4) || (f3 == 3'd5);
      if (!ok) return 1'b1;
      if (sz == 1 && a[0]) return 1'b1;
      if (sz == 2 && a[1:0] != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] word);
      int          sh;
      int          v;
      logic [31:0] s;
      sh = 8 * int'(a[1:0]);
      s  = word >> sh;
      if (f3[1:0] == 2'b00) begin
         v = int'(s & 32'hFF);
         if (!f3[2] && v > 127) v = v - 256;
         return 32'(v);
      end
      if (f3[1:0] == 2'b01) begin
         v = int'(s & 32'hFFFF);
         if (!f3[2] && v > 32767) v = v - 65536;
         return 32'(v);
      end
      return word;
   endfunction

   function automatic logic [31:0] modelMerge(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
      int          sh;
      logic [31:0] mask;
      sh   = 8 * int'(a[1:0]);
      mask = (f3[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      return (old & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   // Schedules the expected outputs for a request accepted during cycle c.
   task automatic schedule(input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int c);
      int          lat;
      int          w;
      logic [31:0] rd;
      w  = int'(a[9:2]);
      rd = 32'h0;
      if (modelFault(we, f3, a)) begin
         lat = 1;
      end else if (we && f3 == 3'd2) begin
         lat = 2;
         expWe[c+1] = 1'b1; expWdata[c+1] = wd; expAddr[c+1] = {a[31:2], 2'b00};
         modelMem[w] = wd;
      end else if (we) begin
         lat = 4;
         expWe[c+3] = 1'b1;
         expWdata[c+3] = modelMerge(f3, a, modelMem[w], wd);
         expAddr[c+3] = {a[31:2], 2'b00};
         modelMem[w] = expWdata[c+3];
      end else begin
         lat = 3;
         rd  = modelLoad(f3, a, modelMem[w]);
      end
      for (int k = 1; k <= lat; k++) expReady[c+k] = 1'b0;
      expValid[c+lat] = 1'b1;
      expFault[c+lat] = modelFault(we, f3, a);
      expRdata[c+lat] = rd;
   endtask

   // Presents a request (called at a negedge) and holds it until accepted.
   task automatic applyStimulus(input bit we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output int acc);
      int n;
      n = 0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #1;
      while (!req_ready && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      acc = cyc;
      if (!req_ready) begin
         checkOutput("accept_timeout", 32'(req_ready), 32'd1);
      end else begin
         schedule(we, f3, a, wd, acc);
      end
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
   endtask

   task automatic waitCycle(input int target);
      int n;
      n = 0;
      while (cyc < target && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (cyc != target) checkOutput("wait_cycle", 32'(cyc), 32'(target));
   endtask

   // Per-cycle compare against the scheduled expectations.
   always @(negedge clk) begin
      if (checkEn && cyc < NCYC) begin
         checkOutput("req_ready", 32'(req_ready), 32'(expReady[cyc]));
         checkOutput("resp_valid", 32'(resp_valid), 32'(expValid[cyc]));
         checkOutput("mem_we", 32'(mem_we), 32'(expWe[cyc]));
         if (expValid[cyc]) begin
            checkOutput("resp_fault", 32'(resp_fault), 32'(expFault[cyc]));
            checkOutput("resp_rdata", resp_rdata, expRdata[cyc]);
         end
         if (expWe[cyc]) begin
            checkOutput("mem_wdata", mem_wdata, expWdata[cyc]);
            checkOutput("mem_addr", mem_addr, expAddr[cyc]);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acc;
      int acc2;
      int r;
      logic [31:0] saved;

      for (int i = 0; i < NCYC; i++) begin
         expReady[i] = 1'b1; expValid[i] = 1'b0; expFault[i] = 1'b0;
         expRdata[i] = 32'h0; expWe[i] = 1'b0; expWdata[i] = 32'h0; expAddr[i] = 32'h0;
      end
      for (int i = 0; i < 256; i++) modelMem[i] = initWord(i);

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_fault", 32'(resp_fault), 32'd0);
      checkOutput("rst_rdata", resp_rdata, 32'h0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);

      // Release reset; the first request is taken at the first rising edge
      r = cyc;
      rst = 1'b1;
      checkEn = 1'b1;
      applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, acc);
      checkOutput("first_accept", 32'(acc), 32'(r));
      waitCycle(acc + 3);
      checkOutput("lb_valid", 32'(resp_valid), 32'd1);
      checkOutput("lb_rdata", resp_rdata, 32'hFFFF_FF88);
      checkOutput("lb_fault", 32'(resp_fault), 32'd0);

      applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, acc);
      waitCycle(acc + 3);
      checkOutput("lhu_rdata", resp_rdata, 32'h0000_8877);

      applyStimulus(1'b0, 3'b001, 32'h10, 32'h0, acc);
      waitCycle(acc + 3);
      checkOutput("lh_rdata", resp_rdata, 32'h0000_6655);

      applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, acc);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, acc);
      applyStimulus(1'b0, 3'b000, 32'h11, 32'h0, acc);

      // SB read-modify-write
      applyStimulus(1'b1, 3'b010, 32'h10, 32'h1122_3344, acc);
      applyStimulus(1'b1, 3'b000, 32'h11, 32'h0000_00AB, acc);
      waitCycle(acc + 3);
      checkOutput("sb_mem_we", 32'(mem_we), 32'd1);
      checkOutput("sb_mem_wdata", mem_wdata, 32'h1122_AB44);
      waitCycle(acc + 4);
      checkOutput("sb_resp_valid", 32'(resp_valid), 32'd1);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, acc);
      waitCycle(acc + 3);
      checkOutput("sb_readback", resp_rdata, 32'h1122_AB44);

      // SW followed by LW
      applyStimulus(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, acc);
      waitCycle(acc + 1);
      checkOutput("sw_mem_we", 32'(mem_we), 32'd1);
      waitCycle(acc + 2);
      checkOutput("sw_resp_valid", 32'(resp_valid), 32'd1);
      applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, acc);
      waitCycle(acc + 3);
      checkOutput("sw_readback", resp_rdata, 32'hDEAD_BEEF);

      // SH upper lane and signed halfword loads
      applyStimulus(1'b1, 3'b001, 32'h16, 32'h1234_F00D, acc);
      applyStimulus(1'b0, 3'b001, 32'h16, 32'h0, acc);
      applyStimulus(1'b0, 3'b000, 32'h17, 32'h0, acc);
      applyStimulus(1'b1, 3'b000, 32'h24, 32'h0000_0077, acc);
      applyStimulus(1'b0, 3'b010, 32'h24, 32'h0, acc);

      // Faults, back-to-back with minimum spacing
      applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, acc);
      waitCycle(acc + 1);
      checkOutput("lw_mis_fault", 32'(resp_fault), 32'd1);
      checkOutput("lw_mis_rdata", resp_rdata, 32'h0);
      applyStimulus(1'b1, 3'b001, 32'h21, 32'h5555, acc2);
      checkOutput("fault_spacing", 32'(acc2 - acc), 32'd2);
      waitCycle(acc2 + 1);
      checkOutput("sh_mis_fault", 32'(resp_fault), 32'd1);
      applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, acc);
      waitCycle(acc + 1);
      checkOutput("f3_011_valid", 32'(resp_valid), 32'd1);
      checkOutput("f3_011_fault", 32'(resp_fault), 32'd1);
      checkOutput("f3_011_rdata", resp_rdata, 32'h0);
      applyStimulus(1'b1, 3'b100, 32'h20, 32'h0, acc);
      applyStimulus(1'b0, 3'b110, 32'h20, 32'h0, acc);

      // Reset during DATA of an SB aborts it
      saved = modelMem[12];
      applyStimulus(1'b1, 3'b000, 32'h31, 32'h0000_0055, acc);
      waitCycle(acc + 2);
      #3;
      rst = 1'b0;
      for (int k = acc + 3; k < acc + 12; k++) begin
         expReady[k] = 1'b1; expValid[k] = 1'b0; expWe[k] = 1'b0;
      end
      modelMem[12] = saved;
      #1;
      checkOutput("abort_ready", 32'(req_ready), 32'd1);
      checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
      checkOutput("abort_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, acc);
      waitCycle(acc + 3);
      checkOutput("abort_lw", resp_rdata, 32'hCAFE_F00D);

      repeat (6) @(negedge clk);
      checkEn = 1'b0;
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed at RV32.
REQ-002 clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 req_valid  input  1  pipeline load/store request.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and faults.
REQ-012 resp_fault  output  1  misaligned access or unsupported funct3; valid with resp_valid.
REQ-013 mem_we  output  1  word write strobe to the synchronous data memory.
REQ-014 mem_addr  output  32  word-aligned byte address: {addr_q[31:2],2'b00}.
REQ-015 mem_wdata  output  32  full word to write.
REQ-016 mem_rdata  input  32  memory read data, registered one cycle after the address is presented.

Function
REQ-017 States: IDLE, READ, DATA, WRITE, RESP; state is one-hot or binary, and that choice is free.
REQ-018 Acceptance: req_valid && req_ready at a rising edge; req_we, req_funct3, req_addr and req_wdata are latched into registers (the _q values) at that edge.
REQ-019 Supported codes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-020 A request is a fault when its code is unsupported, when it is a halfword with addr[0]=1, or when it is a word with addr[1:0]!=0.
REQ-021 A faulting request goes IDLE->RESP, never asserts mem_we, and drives resp_fault=1 and resp_rdata=0.
REQ-022 Load path: IDLE->READ->DATA->RESP; resp_valid asserts 3 cycles after the accept edge.
REQ-023 In READ, mem_addr is driven and mem_we=0; in DATA, mem_rdata is sampled and the extracted byte/half/word is registered into resp_rdata.
REQ-024 Load extraction selects the lane given by addr_q[1:0] (byte) or addr_q[1] (half); LB/LH sign-extend and LBU/LHU zero-extend.
REQ-025 SW path: IDLE->WRITE->RESP; mem_we=1 and mem_wdata=wdata_q during the WRITE cycle only.
REQ-026 SB/SH path (read-modify-write): IDLE->READ->DATA->WRITE->RESP.
REQ-027 In DATA, the merged word is registered: mem_rdata with the selected lane replaced by wdata_q[7:0] or wdata_q[15:0]; the other lanes are unchanged.
REQ-028 In WRITE, mem_wdata carries the merged word.
REQ-029 mem_we is high only in WRITE.
REQ-030 Outside READ, DATA and WRITE, mem_addr holds the last addr_q-derived value and mem_wdata holds its last value.
REQ-031 RESP lasts exactly one cycle with resp_valid=1, then the FSM returns to IDLE.
REQ-032 A request presented in the RESP cycle is not accepted; it is accepted in the following IDLE cycle, giving a minimum spacing of 2 cycles between acceptances.
REQ-033 req_valid while the block is busy is ignored without side effects; the requester must hold req_valid until req_ready.
REQ-034 resp_valid and resp_fault are registered outputs; req_ready is decoded from state only.

Reset
REQ-035 On rst=0, asynchronously: state=IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-036 Reset asserted mid-operation aborts the operation with no response pulse.
REQ-037 A store that is in WRITE when reset asserts has mem_we drop immediately; whether the memory completes that write is unspecified.
REQ-038 After rst rises, the first acceptance can occur at the first rising edge.

Verification
REQ-039 Memory word 0x10 = 0x8877_6655; LB addr 0x13 -> resp_rdata=0xFFFF_FF88 at accept+3, resp_fault=0.
REQ-040 Same word; LHU addr 0x12 -> resp_rdata=0x0000_8877; LH addr 0x10 -> 0x0000_6655.
REQ-041 SB addr 0x11, wdata 0x0000_00AB onto word 0x1122_3344 -> mem_we pulse at accept+3 with mem_wdata=0x1122_AB44; resp_valid at accept+4.
REQ-042 SW addr 0x20, wdata 0xDEAD_BEEF -> mem_we=1 at accept+1 only, resp_valid at accept+2; a following LW addr 0x20 returns 0xDEAD_BEEF.
REQ-043 LW addr 0x22, SH addr 0x21 and funct3=011 -> each gives resp_fault=1 and resp_rdata=0 at accept+1, with mem_we never asserted.
REQ-044 rst pulsed low during the DATA state of an SB -> mem_we never asserts, no resp_valid, req_ready=1 immediately, and the next LW completes normally.
